ram_dp_param: RTL and testbench

Parametrised two-port (one write, one read) synchronous RAM, the successor of the 8x8 single-port test RAM. It adds configurable width and depth, per-byte write enables and a configurable read latency with a `rd_valid` strobe. It also adds write-first bypass on same-address collisions and an optional post-reset hardware clear sequence. It serves as the generic storage block for lab datapaths and as the reference target for the scoreboard-based benches.

---
 rtl/ram_dp_param_if.sv | 37 +++
 rtl/ram_dp_param.sv | 164 ++++++++++++++++
 tb/tb_ram_dp_param.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dp_param_if.sv
// ram_dp_param_if
//   Bus bundle for the one-write/one-read RAM ram_dp_param.
//   master: the requester. It drives the write/read requests and receives
//           read data and status.
//   slave : the RAM side.
//   Signals:
//     wr_en, wr_addr, wr_data, wr_be : write request (bytes gated by wr_be)
//     rd_en, rd_addr                 : read request
//     rd_data, rd_valid              : read return (strobe per accepted read)
//     init_busy                      : post-reset clear in progress
//     wr_err, rd_err                 : request dropped during clear (pulses)
interface ram_dp_param_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   logic                  wr_en;
   logic [ADDR_W-1:0]     wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic [DATA_W/8-1:0]   wr_be;
   logic                  rd_en;
   logic [ADDR_W-1:0]     rd_addr;
   logic [DATA_W-1:0]     rd_data;
   logic                  rd_valid;
   logic                  init_busy;
   logic                  wr_err;
   logic                  rd_err;

   modport master (
      output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      input  rd_data, rd_valid, init_busy, wr_err, rd_err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      output rd_data, rd_valid, init_busy, wr_err, rd_err
   );
endinterface

// File: rtl/ram_dp_param.sv
// ram_dp_param
//   Parametrised synchronous RAM with one write port and one read port.
//   It has per-byte write enables and a RD_LAT-deep read pipeline with a
//   rd_valid strobe. A read and a write to the same address in the same
//   cycle use write-first bypass. An optional zero-fill sequence runs after
//   every reset.
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous, active-high reset
//     bus : ram_dp_param_if.slave (requests in; read data and status out)
//   Parameters:
//     DATA_W       : data width, a multiple of 8 (8..64)
//     ADDR_W       : address width, DEPTH = 2**ADDR_W
//     RD_LAT       : read latency in cycles (1..4)
//     CLEAR_ON_RST : 1 = zero every location after reset, 0 = keep contents
module ram_dp_param #(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 3,
   parameter int RD_LAT       = 1,
   parameter bit CLEAR_ON_RST = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   ram_dp_param_if.slave  bus
);

   localparam int          DEPTH  = 2 ** ADDR_W;
   localparam int unsigned NBYTES = DATA_W / 8;

   typedef enum logic {
      INIT,
      READY
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [ADDR_W-1:0]   ptr;
   logic [ADDR_W-1:0]   ptr_next;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                busy;
   logic                wr_acc;
   logic                rd_acc;
   logic [DATA_W-1:0]   rd_word;

   logic [RD_LAT-1:0]   v_pipe;
   logic [DATA_W-1:0]   d_pipe [RD_LAT];
   logic                wr_err_q;
   logic                rd_err_q;

   assign busy = (state == INIT);

   // Requests are accepted only outside the clear sequence.
   always_comb begin
      wr_acc = bus.wr_en && !busy;
      rd_acc = bus.rd_en && !busy;
   end

   // ---------------------------------------------------------------------
   // Control FSM: clear pointer walks 0..DEPTH-1, then the block is ready.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR_ON_RST ? INIT : READY;
         ptr   <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      case (state)
         INIT: begin
            ptr_next = ptr + 1'b1;
            if (ptr == ADDR_W'(DEPTH - 1)) begin
               state_next = READY;
            end
         end
         READY: begin
            state_next = READY;
         end
         default: begin
            state_next = READY;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Storage. It is not reset, so contents survive rst when no clear runs.
   // Nothing is written in a reset cycle.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (busy) begin
            mem[ptr] <= '0;
         end else if (wr_acc) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
               if (bus.wr_be[i]) begin
                  mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
               end
            end
         end
      end
   end

   // Write-first bypass: enabled bytes of a same-address write replace the
   // stored bytes in the word that enters the read pipeline.
   always_comb begin
      rd_word = mem[bus.rd_addr];
      if (wr_acc && (bus.wr_addr == bus.rd_addr)) begin
         for (int unsigned i = 0; i < NBYTES; i++) begin
            if (bus.wr_be[i]) begin
               rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Read pipeline. Each data stage loads only when a valid read enters
   // it. The last stage therefore holds its value between strobes.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         v_pipe <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            d_pipe[i] <= '0;
         end
      end else begin
         v_pipe[0] <= rd_acc;
         if (rd_acc) begin
            d_pipe[0] <= rd_word;
         end
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            v_pipe[i] <= v_pipe[i-1];
            if (v_pipe[i-1]) begin
               d_pipe[i] <= d_pipe[i-1];
            end
         end
      end
   end

   // Dropped-request flags, one cycle after the dropped request.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_err_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         wr_err_q <= bus.wr_en && busy;
         rd_err_q <= bus.rd_en && busy;
      end
   end

   assign bus.rd_data   = d_pipe[RD_LAT-1];
   assign bus.rd_valid  = v_pipe[RD_LAT-1];
   assign bus.init_busy = busy;
   assign bus.wr_err    = wr_err_q;
   assign bus.rd_err    = rd_err_q;

endmodule

// File: tb/tb_ram_dp_param.sv
// tb_ram_dp_param
//   Directed bench for ram_dp_param with two instances:
//     dut_a : DATA_W=8,  RD_LAT=1, CLEAR_ON_RST=1
//     dut_b : DATA_W=16, RD_LAT=3, CLEAR_ON_RST=0
//   Inputs change 1 time unit after a rising edge. Outputs are sampled at
//   the same point.
module tb_ram_dp_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;

   int n_checks = 0;
   int n_fail   = 0;

   ram_dp_param_if #(.DATA_W(8),  .ADDR_W(3)) bus_a ();
   ram_dp_param_if #(.DATA_W(16), .ADDR_W(3)) bus_b ();

   ram_dp_param #(.DATA_W(8), .ADDR_W(3), .RD_LAT(1), .CLEAR_ON_RST(1'b1)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   ram_dp_param #(.DATA_W(16), .ADDR_W(3), .RD_LAT(3), .CLEAR_ON_RST(1'b0)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

   // Pattern for back-to-back reads on dut_b (with one gap).
   logic [2:0]  pat_addr [5] = '{3'd0, 3'd1, 3'd0, 3'd3, 3'd4};
   logic        pat_en   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [15:0] pat_exp  [5] = '{16'h0010, 16'h0020, 16'h0000, 16'h0030, 16'h0040};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_a(input logic [2:0] addr, input logic [7:0] data);
      bus_a.wr_en   = 1'b1;
      bus_a.wr_addr = addr;
      bus_a.wr_data = data;
      bus_a.wr_be   = 1'b1;
      step();
      bus_a.wr_en   = 1'b0;
   endtask

   task automatic rd_a(input string tag, input logic [2:0] addr, input logic [7:0] exp);
      bus_a.rd_en   = 1'b1;
      bus_a.rd_addr = addr;
      step();
      bus_a.rd_en   = 1'b0;
      check({tag, "_valid"}, bus_a.rd_valid, 1'b1);
      check({tag, "_data"}, bus_a.rd_data, exp);
   endtask

   task automatic wr_b(input logic [2:0] addr, input logic [15:0] data, input logic [1:0] be);
      bus_b.wr_en   = 1'b1;
      bus_b.wr_addr = addr;
      bus_b.wr_data = data;
      bus_b.wr_be   = be;
      step();
      bus_b.wr_en   = 1'b0;
   endtask

   task automatic rd_b(input string tag, input logic [2:0] addr, input logic [15:0] exp);
      bus_b.rd_en   = 1'b1;
      bus_b.rd_addr = addr;
      step();
      bus_b.rd_en   = 1'b0;
      step();
      check({tag, "_early"}, bus_b.rd_valid, 1'b0);
      step();
      check({tag, "_valid"}, bus_b.rd_valid, 1'b1);
      check({tag, "_data"}, bus_b.rd_data, exp);
   endtask

   // Counts cycles with init_busy high on dut_a, bounded, and records any
   // rd_valid seen meanwhile.
   task automatic count_busy_a(output int n, output int nv);
      n  = 0;
      nv = 0;
      while (bus_a.init_busy === 1'b1 && n < 40) begin
         n++;
         step();
         if (bus_a.rd_valid !== 1'b0) nv++;
      end
   endtask

   initial begin
      int   n;
      int   nv;
      logic expv;
      logic [15:0] held;

      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.wr_be = '0;
      bus_a.rd_en = 1'b0; bus_a.rd_addr = '0;
      bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.wr_be = '0;
      bus_b.rd_en = 1'b0; bus_b.rd_addr = '0;

      step();
      check("a_rst_busy",   bus_a.init_busy, 1'b1);
      check("a_rst_valid",  bus_a.rd_valid,  1'b0);
      check("a_rst_data",   bus_a.rd_data,   8'h00);
      check("a_rst_wr_err", bus_a.wr_err,    1'b0);
      check("a_rst_rd_err", bus_a.rd_err,    1'b0);
      check("b_rst_busy",   bus_b.init_busy, 1'b0);
      check("b_rst_valid",  bus_b.rd_valid,  1'b0);
      check("b_rst_data",   bus_b.rd_data,   16'h0000);
      rst_a = 1'b0;
      rst_b = 1'b0;

      // dut_a: clear lasts exactly DEPTH cycles, all locations read zero.
      count_busy_a(n, nv);
      check("a_init_len", n, 8);
      check("a_init_no_valid", nv, 0);
      for (int k = 0; k < 8; k++) begin
         rd_a("a_clear", 3'(k), 8'h00);
      end

      // dut_a: writes then back-to-back reads, latency 1.
      wr_a(3'd0, 8'd10);
      wr_a(3'd1, 8'd20);
      wr_a(3'd3, 8'd30);
      wr_a(3'd4, 8'd40);
      bus_a.rd_en = 1'b1;
      bus_a.rd_addr = 3'd0; step();
      check("a_b2b0_v", bus_a.rd_valid, 1'b1); check("a_b2b0_d", bus_a.rd_data, 8'd10);
      bus_a.rd_addr = 3'd1; step();
      check("a_b2b1_v", bus_a.rd_valid, 1'b1); check("a_b2b1_d", bus_a.rd_data, 8'd20);
      bus_a.rd_addr = 3'd3; step();
      check("a_b2b3_v", bus_a.rd_valid, 1'b1); check("a_b2b3_d", bus_a.rd_data, 8'd30);
      bus_a.rd_addr = 3'd4; step();
      check("a_b2b4_v", bus_a.rd_valid, 1'b1); check("a_b2b4_d", bus_a.rd_data, 8'd40);
      bus_a.rd_en = 1'b0;
      step();
      check("a_idle_valid", bus_a.rd_valid, 1'b0);
      check("a_hold_data",  bus_a.rd_data,  8'd40);

      // dut_a: write-first collision, full and empty byte enables.
      wr_a(3'd5, 8'h11);
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 3'd5; bus_a.wr_data = 8'h22; bus_a.wr_be = 1'b1;
      bus_a.rd_en = 1'b1; bus_a.rd_addr = 3'd5;
      step();
      bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0;
      check("a_coll_be1", bus_a.rd_data, 8'h22);
      wr_a(3'd5, 8'h11);
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 3'd5; bus_a.wr_data = 8'h99; bus_a.wr_be = 1'b0;
      bus_a.rd_en = 1'b1; bus_a.rd_addr = 3'd5;
      step();
      bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0;
      check("a_coll_be0", bus_a.rd_data, 8'h11);
      rd_a("a_be0_noop", 3'd5, 8'h11);

      // dut_a: requests during clear are dropped with error pulses.
      rst_a = 1'b1;
      step();
      rst_a = 1'b0;
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 3'd1; bus_a.wr_data = 8'h55; bus_a.wr_be = 1'b1;
      bus_a.rd_en = 1'b1; bus_a.rd_addr = 3'd1;
      step();
      bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0;
      check("a_drop_wr_err", bus_a.wr_err,   1'b1);
      check("a_drop_rd_err", bus_a.rd_err,   1'b1);
      check("a_drop_valid",  bus_a.rd_valid, 1'b0);
      step();
      check("a_wr_err_pulse", bus_a.wr_err, 1'b0);
      check("a_rd_err_pulse", bus_a.rd_err, 1'b0);
      // Reset mid-clear restarts the full count.
      rst_a = 1'b1;
      step();
      rst_a = 1'b0;
      count_busy_a(n, nv);
      check("a_reinit_len", n, 8);
      check("a_reinit_no_valid", nv, 0);
      rd_a("a_drop_addr1", 3'd1, 8'h00);
      rd_a("a_recleared0", 3'd0, 8'h00);
      rd_a("a_recleared5", 3'd5, 8'h00);

      // dut_b: writes then patterned reads, latency 3.
      wr_b(3'd0, 16'h0010, 2'b11);
      wr_b(3'd1, 16'h0020, 2'b11);
      wr_b(3'd3, 16'h0030, 2'b11);
      wr_b(3'd4, 16'h0040, 2'b11);
      held = 16'h0000;
      for (int t = 0; t < 9; t++) begin
         if (t < 5) begin
            bus_b.rd_en = pat_en[t];
            bus_b.rd_addr = pat_addr[t];
         end else begin
            bus_b.rd_en = 1'b0;
         end
         step();
         expv = 1'b0;
         if (t >= 2 && t < 7) begin
            expv = pat_en[t-2];
            if (expv) held = pat_exp[t-2];
         end
         check("b_pat_valid", bus_b.rd_valid, expv);
         check("b_pat_data",  bus_b.rd_data,  held);
      end

      // dut_b: byte enables.
      wr_b(3'd2, 16'hABCD, 2'b11);
      wr_b(3'd2, 16'h1234, 2'b01);
      rd_b("b_be_lo", 3'd2, 16'hAB34);
      wr_b(3'd2, 16'h5600, 2'b10);
      rd_b("b_be_hi", 3'd2, 16'h5634);

      // dut_b: partial-byte collision bypass.
      wr_b(3'd5, 16'h0011, 2'b11);
      bus_b.wr_en = 1'b1; bus_b.wr_addr = 3'd5; bus_b.wr_data = 16'h2222; bus_b.wr_be = 2'b01;
      bus_b.rd_en = 1'b1; bus_b.rd_addr = 3'd5;
      step();
      bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0;
      step();
      step();
      check("b_coll_valid", bus_b.rd_valid, 1'b1);
      check("b_coll_data",  bus_b.rd_data,  16'h0022);
      rd_b("b_coll_stored", 3'd5, 16'h0022);

      // dut_b: reset kills in-flight reads, contents retained.
      wr_b(3'd6, 16'h0077, 2'b11);
      bus_b.rd_en = 1'b1; bus_b.rd_addr = 3'd6;
      step();
      step();
      bus_b.rd_en = 1'b0;
      rst_b = 1'b1;
      step();
      rst_b = 1'b0;
      check("b_kill_data0", bus_b.rd_data,   16'h0000);
      check("b_kill_busy",  bus_b.init_busy, 1'b0);
      nv = 0;
      for (int t = 0; t < 6; t++) begin
         if (bus_b.rd_valid !== 1'b0) nv++;
         step();
      end
      check("b_kill_no_valid", nv, 0);
      rd_b("b_retain6", 3'd6, 16'h0077);
      rd_b("b_retain2", 3'd2, 16'h5634);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
